// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control sequencer for the MIPS-subset core.
//
// Each instruction walks IF -> ID -> EX -> (MEM) -> (WB) so one memory port and
// one ALU serve the whole datapath. Outputs are combinational from the state,
// the opcode/func latched in ID, the ALU zero flag and (in IF/MEM) mem_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_data         IR contents, stable from the cycle after ir_wr
//   zero              ALU zero flag, valid in EX
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_wr    memory request / request is a store
//   mem_iord          0 = instruction address (PC), 1 = data address (ALU)
//   ir_wr, pc_wr      IR load, PC update
//   pc_src            00 PC+4, 01 branch, 10 jump, 11 rs (jr)
//   regrt, jal, sext, mtoreg   decode-stage selects
//   alu_srcb, alu_op  ALU operand-B select and operation
//   reg_wr            register-file write strobe
//   illegal           one-cycle pulse on an unsupported opcode/func
//   instr_done        one-cycle pulse when an instruction retires
//   instr_cnt         retired-instruction count (wraps)
module mc_ctrl_fsm #(
    parameter int unsigned P_CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst_data,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_wr,
    output logic               mem_iord,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_src,
    output logic               regrt,
    output logic               jal,
    output logic               sext,
    output logic               mtoreg,
    output logic               alu_srcb,
    output logic [3:0]         alu_op,
    output logic               reg_wr,
    output logic               illegal,
    output logic               instr_done,
    output logic [P_CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIf   = 3'd1,
        StId   = 3'd2,
        StEx   = 3'd3,
        StMem  = 3'd4,
        StWb   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluSll = 4'b0100;
    localparam logic [3:0] AluLui = 4'b0101;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [5:0]         func_q, func_d;
    logic [P_CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Only the opcode and func fields are decoded here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_data[25:6];

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] func);
        logic ok;
        ok = 1'b0;
        case (op)
            OpRtype: begin
                case (func)
                    FnAdd, FnSub, FnAnd, FnOr, FnSll, FnJr: ok = 1'b1;
                    default:                                ok = 1'b0;
                endcase
            end
            OpAddi, OpAndi, OpOri, OpLui, OpLw, OpSw, OpBeq, OpJ, OpJal: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        func_d     = func_q;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_iord   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        regrt      = 1'b0;
        jal        = 1'b0;
        sext       = 1'b0;
        mtoreg     = 1'b0;
        alu_srcb   = 1'b0;
        alu_op     = AluAdd;
        reg_wr     = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        unique case (state_q)
            StIdle: state_d = StIf;

            StIf: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = StId;
                end
            end

            // ID decodes the live IR; later phases use only the latched fields.
            StId: begin
                op_d   = inst_data[31:26];
                func_d = inst_data[5:0];
                if (is_legal(inst_data[31:26], inst_data[5:0])) begin
                    state_d = StEx;
                end else begin
                    illegal = 1'b1;
                    state_d = StIf;
                end
            end

            StEx: begin
                state_d = StWb;
                case (op_q)
                    OpRtype: begin
                        case (func_q)
                            FnSub: alu_op = AluSub;
                            FnAnd: alu_op = AluAnd;
                            FnOr:  alu_op = AluOr;
                            FnSll: begin
                                alu_op   = AluSll;
                                alu_srcb = 1'b1;
                            end
                            FnJr: begin
                                pc_wr      = 1'b1;
                                pc_src     = 2'b11;
                                instr_done = 1'b1;
                                state_d    = StIf;
                            end
                            default: alu_op = AluAdd;
                        endcase
                    end
                    OpAddi: begin
                        sext     = 1'b1;
                        alu_srcb = 1'b1;
                    end
                    OpLw, OpSw: begin
                        sext     = 1'b1;
                        alu_srcb = 1'b1;
                        state_d  = StMem;
                    end
                    OpAndi: begin
                        alu_srcb = 1'b1;
                        alu_op   = AluAnd;
                    end
                    OpOri: begin
                        alu_srcb = 1'b1;
                        alu_op   = AluOr;
                    end
                    OpLui: begin
                        alu_srcb = 1'b1;
                        alu_op   = AluLui;
                    end
                    OpBeq: begin
                        alu_op = AluSub;
                        if (zero) begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b01;
                            sext   = 1'b1;
                        end
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end
                    OpJ: begin
                        pc_wr      = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end
                    OpJal: begin
                        pc_wr  = 1'b1;
                        pc_src = 2'b10;
                    end
                    default: state_d = StIf;
                endcase
            end

            StMem: begin
                mem_req  = 1'b1;
                mem_iord = 1'b1;
                mem_wr   = (op_q == OpSw);
                if (mem_ready) begin
                    if (op_q == OpSw) begin
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end
            end

            // Only R-type, jal and I-type ALU/lw reach WB.
            StWb: begin
                reg_wr     = 1'b1;
                regrt      = (op_q != OpRtype) && (op_q != OpJal);
                jal        = (op_q == OpJal);
                mtoreg     = (op_q == OpLw);
                instr_done = 1'b1;
                state_d    = StIf;
            end

            default: state_d = StIdle;
        endcase

        instr_cnt_d = instr_done ? instr_cnt_q + P_CNT_W'(1) : instr_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 6'h00;
            func_q      <= 6'h00;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            func_q      <= func_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-cycle table of {inputs, expected outputs},
// plus a hand-written reset-during-MEM-stall sequence. Counter width is 4 so the
// wrap-around can be reached with 16 retirements.
module tb_mc_ctrl_fsm;

    localparam int unsigned CW = 4;

    // Expected-output bit layout:
    // 18 mem_req, 17 mem_wr, 16 mem_iord, 15 ir_wr, 14 pc_wr, 13:12 pc_src,
    // 11 regrt, 10 jal, 9 sext, 8 mtoreg, 7 alu_srcb, 6:3 alu_op,
    // 2 reg_wr, 1 illegal, 0 instr_done
    localparam logic [18:0] O_REQ  = 19'h40000;
    localparam logic [18:0] O_WR   = 19'h20000;
    localparam logic [18:0] O_IORD = 19'h10000;
    localparam logic [18:0] O_IRWR = 19'h08000;
    localparam logic [18:0] O_PCWR = 19'h04000;
    localparam logic [18:0] O_PCB  = 19'h01000;
    localparam logic [18:0] O_PCJ  = 19'h02000;
    localparam logic [18:0] O_PCR  = 19'h03000;
    localparam logic [18:0] O_RT   = 19'h00800;
    localparam logic [18:0] O_JAL  = 19'h00400;
    localparam logic [18:0] O_SEXT = 19'h00200;
    localparam logic [18:0] O_MTR  = 19'h00100;
    localparam logic [18:0] O_SRCB = 19'h00080;
    localparam logic [18:0] A_SUB  = 19'h00008;
    localparam logic [18:0] A_AND  = 19'h00010;
    localparam logic [18:0] A_OR   = 19'h00018;
    localparam logic [18:0] A_SLL  = 19'h00020;
    localparam logic [18:0] A_LUI  = 19'h00028;
    localparam logic [18:0] O_RWR  = 19'h00004;
    localparam logic [18:0] O_ILL  = 19'h00002;
    localparam logic [18:0] O_DONE = 19'h00001;
    localparam logic [18:0] IF_R   = O_REQ | O_IRWR | O_PCWR;

    logic          clk;
    logic          rst_n;
    logic [31:0]   inst_data;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, mem_wr, mem_iord, ir_wr, pc_wr;
    logic [1:0]    pc_src;
    logic          regrt, jal, sext, mtoreg, alu_srcb;
    logic [3:0]    alu_op;
    logic          reg_wr, illegal, instr_done;
    logic [CW-1:0] instr_cnt;
    logic [18:0]   act;

    assign act = {mem_req, mem_wr, mem_iord, ir_wr, pc_wr, pc_src, regrt, jal, sext,
                  mtoreg, alu_srcb, alu_op, reg_wr, illegal, instr_done};

    mc_ctrl_fsm #(.P_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_data  (inst_data),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_iord   (mem_iord),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .regrt      (regrt),
        .jal        (jal),
        .sext       (sext),
        .mtoreg     (mtoreg),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .reg_wr     (reg_wr),
        .illegal    (illegal),
        .instr_done (instr_done),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic          rdy;
        logic          z;
        logic [31:0]   ins;
        logic [18:0]   exp_out;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   excl_viol = 0;

    task automatic v(input string nm, input logic rst, input logic rdy, input logic z,
                     input logic [31:0] ins, input logic [18:0] e, input logic [CW-1:0] c);
        vec_t t;
        t.name = nm; t.rst = rst; t.rdy = rdy; t.z = z; t.ins = ins;
        t.exp_out = e; t.exp_cnt = c;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [18:0] e, input logic [CW-1:0] c);
        tests++;
        if (pc_wr && reg_wr) excl_viol++;
        if (act !== e || instr_cnt !== c) begin
            fails++;
            $display("FAIL %s: got out=%05h cnt=%0d, want out=%05h cnt=%0d",
                     nm, act, instr_cnt, e, c);
        end
    endtask

    initial begin
        rst_n = 1'b0; inst_data = 32'h0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held 3 cycles, then one IDLE cycle, then IF.
        for (int i = 0; i < 3; i++) v("reset", 0, 1, 0, 32'h0, 19'h0, 0);
        v("idle", 1, 1, 0, 32'h0, 19'h0, 0);
        // add
        v("add_if", 1, 1, 0, 32'h012A4020, IF_R, 0);
        v("add_id", 1, 1, 0, 32'h012A4020, 19'h0, 0);
        v("add_ex", 1, 1, 1, 32'h012A4020, 19'h0, 0);
        v("add_wb", 1, 1, 0, 32'h012A4020, O_RWR | O_DONE, 0);
        // lw with two MEM wait cycles
        v("lw_if",   1, 1, 0, 32'h8D090004, IF_R, 1);
        v("lw_id",   1, 1, 0, 32'h8D090004, 19'h0, 1);
        v("lw_ex",   1, 1, 0, 32'h8D090004, O_SEXT | O_SRCB, 1);
        v("lw_mem0", 1, 0, 0, 32'h8D090004, O_REQ | O_IORD, 1);
        v("lw_mem1", 1, 0, 0, 32'h8D090004, O_REQ | O_IORD, 1);
        v("lw_mem2", 1, 1, 0, 32'h8D090004, O_REQ | O_IORD, 1);
        v("lw_wb",   1, 1, 0, 32'h8D090004, O_RWR | O_RT | O_MTR | O_DONE, 1);
        // beq taken, preceded by an IF stall
        v("beq_ifw", 1, 0, 0, 32'h11090003, O_REQ, 2);
        v("beq_if",  1, 1, 0, 32'h11090003, IF_R, 2);
        v("beq_id",  1, 1, 0, 32'h11090003, 19'h0, 2);
        v("beq_ex1", 1, 1, 1, 32'h11090003, A_SUB | O_PCWR | O_PCB | O_SEXT | O_DONE, 2);
        // beq not taken
        v("beq0_if", 1, 1, 0, 32'h11090003, IF_R, 3);
        v("beq0_id", 1, 1, 0, 32'h11090003, 19'h0, 3);
        v("beq0_ex", 1, 1, 0, 32'h11090003, A_SUB | O_DONE, 3);
        // jal
        v("jal_if", 1, 1, 0, 32'h0C000010, IF_R, 4);
        v("jal_id", 1, 1, 0, 32'h0C000010, 19'h0, 4);
        v("jal_ex", 1, 1, 0, 32'h0C000010, O_PCWR | O_PCJ, 4);
        v("jal_wb", 1, 1, 0, 32'h0C000010, O_RWR | O_JAL | O_DONE, 4);
        // sw
        v("sw_if",  1, 1, 0, 32'hAD090008, IF_R, 5);
        v("sw_id",  1, 1, 0, 32'hAD090008, 19'h0, 5);
        v("sw_ex",  1, 1, 0, 32'hAD090008, O_SEXT | O_SRCB, 5);
        v("sw_mem", 1, 1, 0, 32'hAD090008, O_REQ | O_IORD | O_WR | O_DONE, 5);
        // illegal opcode 0x3F
        v("illop_if", 1, 1, 0, 32'hFC000000, IF_R, 6);
        v("illop_id", 1, 1, 0, 32'hFC000000, O_ILL, 6);
        // sll
        v("sll_if", 1, 1, 0, 32'h00094080, IF_R, 6);
        v("sll_id", 1, 1, 0, 32'h00094080, 19'h0, 6);
        v("sll_ex", 1, 1, 0, 32'h00094080, O_SRCB | A_SLL, 6);
        v("sll_wb", 1, 1, 0, 32'h00094080, O_RWR | O_DONE, 6);
        // jr
        v("jr_if", 1, 1, 0, 32'h03E00008, IF_R, 7);
        v("jr_id", 1, 1, 0, 32'h03E00008, 19'h0, 7);
        v("jr_ex", 1, 1, 0, 32'h03E00008, O_PCWR | O_PCR | O_DONE, 7);
        // ori
        v("ori_if", 1, 1, 0, 32'h352800FF, IF_R, 8);
        v("ori_id", 1, 1, 0, 32'h352800FF, 19'h0, 8);
        v("ori_ex", 1, 1, 0, 32'h352800FF, O_SRCB | A_OR, 8);
        v("ori_wb", 1, 1, 0, 32'h352800FF, O_RT | O_RWR | O_DONE, 8);
        // lui
        v("lui_if", 1, 1, 0, 32'h3C081234, IF_R, 9);
        v("lui_id", 1, 1, 0, 32'h3C081234, 19'h0, 9);
        v("lui_ex", 1, 1, 0, 32'h3C081234, O_SRCB | A_LUI, 9);
        v("lui_wb", 1, 1, 0, 32'h3C081234, O_RT | O_RWR | O_DONE, 9);
        // illegal R-type func 0x3F
        v("illfn_if", 1, 1, 0, 32'h0000003F, IF_R, 10);
        v("illfn_id", 1, 1, 0, 32'h0000003F, O_ILL, 10);
        // sub
        v("sub_if", 1, 1, 0, 32'h012A4022, IF_R, 10);
        v("sub_id", 1, 1, 0, 32'h012A4022, 19'h0, 10);
        v("sub_ex", 1, 1, 0, 32'h012A4022, A_SUB, 10);
        v("sub_wb", 1, 1, 0, 32'h012A4022, O_RWR | O_DONE, 10);
        // addi
        v("addi_if", 1, 1, 0, 32'h21280005, IF_R, 11);
        v("addi_id", 1, 1, 0, 32'h21280005, 19'h0, 11);
        v("addi_ex", 1, 1, 0, 32'h21280005, O_SEXT | O_SRCB, 11);
        v("addi_wb", 1, 1, 0, 32'h21280005, O_RT | O_RWR | O_DONE, 11);
        // andi
        v("andi_if", 1, 1, 0, 32'h3128000F, IF_R, 12);
        v("andi_id", 1, 1, 0, 32'h3128000F, 19'h0, 12);
        v("andi_ex", 1, 1, 0, 32'h3128000F, O_SRCB | A_AND, 12);
        v("andi_wb", 1, 1, 0, 32'h3128000F, O_RT | O_RWR | O_DONE, 12);
        // three j's take the count 13 -> 14 -> 15 -> 0
        for (int k = 0; k < 3; k++) begin
            v("j_if", 1, 1, 0, 32'h08000010, IF_R, CW'(13 + k));
            v("j_id", 1, 1, 0, 32'h08000010, 19'h0, CW'(13 + k));
            v("j_ex", 1, 1, 0, 32'h08000010, O_PCWR | O_PCJ | O_DONE, CW'(13 + k));
        end

        // Inputs change at the falling edge; outputs sampled 1 time unit later.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n     = vecs[i].rst;
            mem_ready = vecs[i].rdy;
            zero      = vecs[i].z;
            inst_data = vecs[i].ins;
            #1;
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_cnt);
        end

        // Wrapped counter visible in the next IF; then reset during a MEM stall.
        @(negedge clk); inst_data = 32'h8D090004; mem_ready = 1'b1; zero = 1'b0; #1;
        check("wrap_if", IF_R, 0);
        @(negedge clk); #1; check("rlw_id", 19'h0, 0);
        @(negedge clk); #1; check("rlw_ex", O_SEXT | O_SRCB, 0);
        @(negedge clk); mem_ready = 1'b0; #1; check("rlw_memw", O_REQ | O_IORD, 0);
        @(posedge clk); #2; check("rlw_memw2", O_REQ | O_IORD, 0);
        rst_n = 1'b0; #1;
        check("rst_abort", 19'h0, 0);
        @(negedge clk); rst_n = 1'b1; #1; check("rst_idle", 19'h0, 0);
        @(negedge clk); mem_ready = 1'b1; #1; check("rst_if", IF_R, 0);

        tests++;
        if (excl_viol != 0) begin
            fails++;
            $display("FAIL pc_wr_reg_wr_excl: got %0d overlaps, want 0", excl_viol);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
